// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory, redirect and fetch-output signals of the fetch stage
interface instr_fetch_if #(parameter int IMEM_AW = 10);
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_rvalid;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic [31:0]        instr;
  logic [31:0]        instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_rdata, imem_rvalid, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_rdata, imem_rvalid, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetcher with 2-entry output buffer and redirect flush
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 10
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;
  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [1:0]  count;
  logic        rd, wr;
  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc [2];
  logic        req, push, pop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  // a response (stale or not) always closes the outstanding request
  always_comb begin
    state_nxt = state == FETCH ? (req ? WAIT : FETCH) :
                bus.imem_rvalid ? FETCH :
                bus.redirect_valid ? DROP : state;
  end
  always_comb begin
    req  = rst_n && state == FETCH && count < 2'd2 && !bus.redirect_valid;
    push = state == WAIT && bus.imem_rvalid && !bus.redirect_valid;
    pop  = bus.instr_valid && bus.instr_ready;
  end
  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc[IMEM_AW-1:0];
  assign bus.instr       = buf_instr[rd];
  assign bus.instr_pc    = buf_pc[rd];
  assign bus.instr_valid = count != 2'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc    <= RESET_PC;
      count <= 2'd0;
      rd    <= 1'b0;
      wr    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_instr[i] <= 32'h0;
        buf_pc[i]    <= 32'h0;
      end
    end else begin
      if (push) begin
        buf_instr[wr] <= bus.imem_rdata;
        buf_pc[wr]    <= pc;
      end
      pc    <= bus.redirect_valid ? bus.redirect_pc : push ? pc + 32'd1 : pc;
      count <= bus.redirect_valid ? 2'd0 : count + 2'(push) - 2'(pop);
      rd    <= bus.redirect_valid ? 1'b0 : rd ^ pop;
      wr    <= bus.redirect_valid ? 1'b0 : wr ^ push;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized memory/consumer environment checked against an instruction-stream model
module tb_instr_fetch;
  localparam int          AW  = 10;
  localparam logic [31:0] RPC = 32'h0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  instr_fetch_if #(.IMEM_AW(AW)) bus();
  instr_fetch #(.RESET_PC(RPC), .IMEM_AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask
  logic [31:0]   mem [1 << AW];
  logic [31:0]   exp_pc, fetch_pc, h_instr, h_pc, force_pc;
  logic [AW-1:0] raddr;
  int            nbuf, cd, cyc, last_pop;
  bit            outst, stale, hold, tput, force_redir, redir_on_rv;
  int            rdy_mode, lat_max, redir_pct;
  task automatic model_reset();
    nbuf = 0; outst = 0; stale = 0; hold = 0;
    exp_pc = RPC; fetch_pc = RPC; last_pop = -1;
  endtask
  // one cycle: drive inputs, then predict and compare what the coming edge will do
  task automatic body();
    bit pop, push;
    cyc++;
    bus.imem_rvalid = 1'b0;
    if (outst) begin
      if (cd == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem[raddr];
      end else cd--;
    end
    if (!bus.imem_rvalid) bus.imem_rdata = $urandom;
    bus.redirect_valid = force_redir || (redir_on_rv && bus.imem_rvalid) ||
                         ($urandom_range(99) < redir_pct);
    bus.redirect_pc = force_redir ? force_pc :
                      ($urandom_range(3) == 0) ? 32'hFFFFFFFE + 32'($urandom_range(1)) : $urandom;
    if (redir_on_rv && bus.imem_rvalid) redir_on_rv = 0;
    force_redir = 0;
    bus.instr_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(1));
    #1;
    if (hold) begin
      check("hold_valid", 64'(bus.instr_valid), 64'd1);
      check("hold_instr", 64'(bus.instr), 64'(h_instr));
      check("hold_pc", 64'(bus.instr_pc), 64'(h_pc));
    end
    check("valid", 64'(bus.instr_valid), 64'(nbuf != 0));
    check("req", 64'(bus.imem_req), 64'(!outst && nbuf < 2 && !bus.redirect_valid));
    if (bus.imem_req) check("addr", 64'(bus.imem_addr), 64'(fetch_pc[AW-1:0]));
    pop = bus.instr_valid && bus.instr_ready;
    if (pop) begin
      check("instr_pc", 64'(bus.instr_pc), 64'(exp_pc));
      check("instr", 64'(bus.instr), 64'(mem[exp_pc[AW-1:0]]));
      if (tput && last_pop >= 0) check("tput", 64'(cyc - last_pop), 64'd2);
      last_pop = cyc;
      exp_pc++;
    end
    hold = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
    h_instr = bus.instr;
    h_pc = bus.instr_pc;
    push = bus.imem_rvalid && !stale && !bus.redirect_valid;
    if (bus.imem_rvalid) outst = 0;
    if (push) fetch_pc++;
    nbuf = nbuf + int'(push) - int'(pop);
    if (bus.redirect_valid) begin
      if (outst) stale = 1;
      nbuf = 0;
      exp_pc = bus.redirect_pc;
      fetch_pc = bus.redirect_pc;
    end
    if (bus.imem_req) begin
      outst = 1; stale = 0;
      cd = $urandom_range(lat_max - 1);
      raddr = bus.imem_addr;
    end
  endtask
  task automatic cycle();
    @(negedge clk);
    body();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid = 1'b0;
    #1;
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_req", 64'(bus.imem_req), 64'd0);
    @(negedge clk);
    check("rst_instr", 64'(bus.instr), 64'd0);
    check("rst_instr_pc", 64'(bus.instr_pc), 64'd0);
    rst_n = 1'b1;
    model_reset();
    body();
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    bus.imem_rdata = 0; bus.imem_rvalid = 0; bus.redirect_valid = 0;
    bus.redirect_pc = 0; bus.instr_ready = 0;
    cyc = 0; cd = 0; raddr = '0; force_pc = 0; h_instr = 0; h_pc = 0;
    force_redir = 0; redir_on_rv = 0; tput = 0;
    rdy_mode = 1; lat_max = 1; redir_pct = 0;
    model_reset();
    do_reset();
    tput = 1;
    repeat (12) cycle();
    tput = 0;
    rdy_mode = 2;
    repeat (10) cycle();
    rdy_mode = 1;
    repeat (8) cycle();
    lat_max = 3;
    repeat (5) cycle();
    force_redir = 1; force_pc = 32'h40;
    repeat (12) cycle();
    lat_max = 1; redir_on_rv = 1;
    repeat (10) cycle();
    force_redir = 1; force_pc = 32'hFFFFFFFF;
    repeat (12) cycle();
    rdy_mode = 2; lat_max = 3;
    for (int i = 0; i < 30 && !(nbuf == 1 && outst); i++) cycle();
    check("full_outst_reached", 64'(nbuf == 1 && outst), 64'd1);
    do_reset();
    rdy_mode = 1;
    repeat (6) cycle();
    rdy_mode = 0; lat_max = 4; redir_pct = 8;
    for (int r = 0; r < 6; r++) begin
      repeat (500) cycle();
      do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
